// File: rtl/gauss_row_feeder_if.sv
// Bus bundle between the row feeder, its word buffer/command source and the
// first processor column of the systolic Gaussian-elimination array.
interface gauss_row_feeder_if #(
    parameter int GF_BIT      = 4,
    parameter int OP_CODE_LEN = 4,
    parameter int WORD_W      = 64,
    parameter int ROW_CNT_W   = 8
) ();

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid must not depend on ready, and the payload is
    // only sampled on a transfer edge.
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [OP_CODE_LEN-1:0] cmd_op;
    logic [ROW_CNT_W-1:0]   cmd_rows;

    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_W-1:0]      in_data;

    logic                   array_en;
    logic                   start_out;
    logic                   finish_out;
    logic [OP_CODE_LEN-1:0] op_out;
    logic [1:0]             gauss_op_out;
    logic [GF_BIT-1:0]      data_out;
    logic                   busy;
    logic                   done;
    logic [1:0]             dbg_state;

    modport master (
        output cmd_valid, cmd_op, cmd_rows, in_valid, in_data,
        input  cmd_ready, in_ready, array_en, start_out, finish_out, op_out,
               gauss_op_out, data_out, busy, done, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rows, in_valid, in_data,
        output cmd_ready, in_ready, array_en, start_out, finish_out, op_out,
               gauss_op_out, data_out, busy, done, dbg_state
    );

endinterface

// File: rtl/gauss_row_feeder.sv
// Transmit end of the systolic Gaussian-elimination stream: unpacks buffered
// words into one GF element per enabled cycle, then flushes the pivot registers.
module gauss_row_feeder #(
    parameter int GF_BIT      = 4,
    parameter int OP_CODE_LEN = 4,
    parameter int N_COLS      = 32,
    parameter int WORD_W      = 64,
    parameter int ROW_CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    gauss_row_feeder_if.slave   bus
);

    localparam int EPW   = WORD_W / GF_BIT;
    localparam int IDX_W = (EPW > 1) ? $clog2(EPW) : 1;
    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EPW - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [WORD_W-1:0]      r_buf;
    logic                   r_buf_valid;
    logic [IDX_W-1:0]       r_idx;
    logic [COL_W-1:0]       r_col;
    logic [ROW_CNT_W-1:0]   r_row;
    logic [ROW_CNT_W-1:0]   r_rows;
    logic [OP_CODE_LEN-1:0] r_op;
    logic                   r_array_en;
    logic                   r_start;
    logic                   r_finish;
    logic                   r_done;
    logic [1:0]             r_gauss;
    logic [GF_BIT-1:0]      r_data;

    logic w_row_end;
    logic w_last_row;
    logic w_final_elem;
    logic w_last_useful;
    logic w_in_ready;
    logic w_in_fire;

    assign w_row_end     = (r_col == COL_LAST);
    assign w_last_row    = (r_row == r_rows - ROW_CNT_W'(1));
    assign w_final_elem  = r_buf_valid && w_row_end && w_last_row;
    // A row's last element also retires the word, dropping its unused tail.
    assign w_last_useful = r_buf_valid && ((r_idx == IDX_LAST) || w_row_end);
    // The very last element of a command never pulls in another word.
    assign w_in_ready    = (r_state == S_STREAM) &&
                           (!r_buf_valid || (w_last_useful && !w_final_elem));
    assign w_in_fire     = w_in_ready && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_idx       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_rows      <= '0;
            r_op        <= '0;
            r_array_en  <= 1'b0;
            r_start     <= 1'b0;
            r_finish    <= 1'b0;
            r_done      <= 1'b0;
            r_gauss     <= 2'b00;
            r_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_array_en <= 1'b0;
                    r_start    <= 1'b0;
                    r_finish   <= 1'b0;
                    r_gauss    <= 2'b00;
                    r_data     <= '0;
                    r_done     <= 1'b0;
                    if (bus.cmd_valid) begin
                        r_op        <= bus.cmd_op;
                        r_rows      <= bus.cmd_rows;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_idx       <= '0;
                        r_buf_valid <= 1'b0;
                        r_state     <= (bus.cmd_rows == '0) ? S_DONE : S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (r_buf_valid) begin
                        r_array_en <= 1'b1;
                        r_start    <= (r_col == '0);
                        r_gauss    <= (r_col == '0) ? 2'b11 : 2'b00;
                        r_data     <= r_buf[GF_BIT-1:0];
                        r_buf      <= r_buf >> GF_BIT;
                        r_idx      <= r_idx + IDX_W'(1);
                        if (w_last_useful) begin
                            r_buf_valid <= 1'b0;
                        end
                        if (w_row_end) begin
                            r_col <= '0;
                            if (w_last_row) begin
                                r_state <= S_FLUSH;
                            end else begin
                                r_row <= r_row + ROW_CNT_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end else begin
                        // Starved: stream outputs hold, only the enable drops.
                        r_array_en <= 1'b0;
                    end
                    if (w_in_fire) begin
                        r_buf       <= bus.in_data;
                        r_buf_valid <= 1'b1;
                        r_idx       <= '0;
                    end
                end

                S_FLUSH: begin
                    // r_col is back at zero here and doubles as the flush counter.
                    r_array_en <= 1'b1;
                    r_start    <= 1'b0;
                    r_finish   <= 1'b1;
                    r_gauss    <= 2'b01;
                    r_data     <= '0;
                    if (w_row_end) begin
                        r_col   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end

                S_DONE: begin
                    r_array_en <= 1'b0;
                    r_start    <= 1'b0;
                    r_finish   <= 1'b0;
                    r_gauss    <= 2'b00;
                    r_data     <= '0;
                    r_done     <= 1'b1;
                    r_state    <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.in_ready     = w_in_ready;
    assign bus.array_en     = r_array_en;
    assign bus.start_out    = r_start;
    assign bus.finish_out   = r_finish;
    assign bus.op_out       = r_op;
    assign bus.gauss_op_out = r_gauss;
    assign bus.data_out     = r_data;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = r_done;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_gauss_row_feeder.sv
// Bench for gauss_row_feeder: two instances (32 and 20 columns) share one
// driver; a queue-based reference model predicts every enabled stream cycle.
module tb_gauss_row_feeder;

    localparam int EPW = 16;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared drive, per-instance gating ----------------
    logic        sel;
    logic        d_cmd_valid;
    logic [3:0]  d_cmd_op;
    logic [7:0]  d_cmd_rows;
    logic        d_in_valid;
    logic [63:0] d_in_data;

    gauss_row_feeder_if #(.GF_BIT(4), .OP_CODE_LEN(4), .WORD_W(64), .ROW_CNT_W(8)) if_a ();
    gauss_row_feeder_if #(.GF_BIT(4), .OP_CODE_LEN(4), .WORD_W(64), .ROW_CNT_W(8)) if_b ();

    assign if_a.cmd_valid = d_cmd_valid && (sel == 1'b0);
    assign if_a.cmd_op    = d_cmd_op;
    assign if_a.cmd_rows  = d_cmd_rows;
    assign if_a.in_valid  = d_in_valid && (sel == 1'b0);
    assign if_a.in_data   = d_in_data;
    assign if_b.cmd_valid = d_cmd_valid && (sel == 1'b1);
    assign if_b.cmd_op    = d_cmd_op;
    assign if_b.cmd_rows  = d_cmd_rows;
    assign if_b.in_valid  = d_in_valid && (sel == 1'b1);
    assign if_b.in_data   = d_in_data;

    gauss_row_feeder #(.GF_BIT(4), .OP_CODE_LEN(4), .N_COLS(32), .WORD_W(64), .ROW_CNT_W(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    gauss_row_feeder #(.GF_BIT(4), .OP_CODE_LEN(4), .N_COLS(20), .WORD_W(64), .ROW_CNT_W(8))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    logic        m_cmd_ready, m_in_ready, m_en, m_start, m_finish, m_busy, m_done;
    logic [3:0]  m_op, m_data;
    logic [1:0]  m_gauss, m_state;
    logic [11:0] m_obs;
    assign m_cmd_ready = sel ? if_b.cmd_ready    : if_a.cmd_ready;
    assign m_in_ready  = sel ? if_b.in_ready     : if_a.in_ready;
    assign m_en        = sel ? if_b.array_en     : if_a.array_en;
    assign m_start     = sel ? if_b.start_out    : if_a.start_out;
    assign m_finish    = sel ? if_b.finish_out   : if_a.finish_out;
    assign m_op        = sel ? if_b.op_out       : if_a.op_out;
    assign m_gauss     = sel ? if_b.gauss_op_out : if_a.gauss_op_out;
    assign m_data      = sel ? if_b.data_out     : if_a.data_out;
    assign m_busy      = sel ? if_b.busy         : if_a.busy;
    assign m_done      = sel ? if_b.done         : if_a.done;
    assign m_state     = sel ? if_b.dbg_state    : if_a.dbg_state;
    assign m_obs       = {m_start, m_finish, m_gauss, m_data, m_op};

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_en     = 0;
    int          n_stall  = 0;
    int          done_cnt = 0;
    bit          phase    = 1'b0;
    bit          abort    = 1'b0;
    logic [11:0] exp_q[$];
    logic [11:0] last_obs = '0;
    logic [63:0] words[0:31];
    int          gaps[0:31];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: each enabled cycle is matched against the model queue; each
    // disabled cycle inside a command must hold the previous stream values.
    always @(negedge clk) begin
        logic [11:0] exp_v;
        if (rst_n) begin
            if (m_en) begin
                n_en++;
                phase = 1'b1;
                if (exp_q.size() != 0) exp_v = exp_q.pop_front();
                else                   exp_v = 12'hFFF;
                check_eq("stream", 64'(m_obs), 64'(exp_v));
                last_obs = m_obs;
            end else if (phase && !m_done) begin
                n_stall++;
                check_eq("starve_hold", 64'(m_obs), 64'(last_obs));
            end
            if (m_done) begin
                phase = 1'b0;
                done_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, 64'(m_cmd_ready), 64'd1);
        check_eq({tag, "_busy"},      64'(m_busy),      64'd0);
        check_eq({tag, "_array_en"},  64'(m_en),        64'd0);
        check_eq({tag, "_in_ready"},  64'(m_in_ready),  64'd0);
        check_eq({tag, "_done"},      64'(m_done),      64'd0);
        check_eq({tag, "_stream"},    64'(m_obs),       64'd0);
        check_eq({tag, "_state"},     64'(m_state),     64'd0);
    endtask

    task automatic wait_in_ready();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!m_in_ready && !abort && t < 200);
        if (!abort) begin
            check_eq("in_ready_wait", 64'(m_in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_words(input int nw, input bit rand_gaps);
        for (int i = 0; i < nw; i++) begin
            words[i] = {$urandom, $urandom};
            gaps[i]  = rand_gaps ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3))) : 0;
        end
    endtask

    task automatic run_cmd(input int rows, input logic [3:0] op, input int abort_at);
        int ncol = sel ? 20 : 32;
        int wpr  = (ncol + EPW - 1) / EPW;
        int nw   = rows * wpr;
        int exp_stall = 0;
        int d0;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < ncol; c++) begin
                logic [63:0] w = words[r * wpr + c / EPW];
                logic [3:0]  e = 4'(w >> (4 * (c % EPW)));
                exp_q.push_back({(c == 0), 1'b0, (c == 0) ? 2'b11 : 2'b00, e, op});
            end
        end
        for (int c = 0; c < ncol; c++) exp_q.push_back({1'b0, 1'b1, 2'b01, 4'h0, op});
        for (int i = 1; i < nw; i++) exp_stall += gaps[i];
        n_en = 0;
        n_stall = 0;
        abort = 1'b0;
        d0 = done_cnt;
        fork
            begin
                int t = 0;
                d_cmd_op = op;
                d_cmd_rows = 8'(rows);
                d_cmd_valid = 1'b1;
                do begin
                    @(negedge clk);
                    t++;
                end while (!m_cmd_ready && t < 50);
                check_eq("cmd_ready_wait", 64'(m_cmd_ready), 64'd1);
                @(posedge clk);
                #1;
                d_cmd_valid = 1'b0;
            end
            begin
                for (int i = 0; i < nw; i++) begin
                    for (int g = 0; g < gaps[i] && !abort; g++) wait_in_ready();
                    if (abort) break;
                    d_in_data = words[i];
                    d_in_valid = 1'b1;
                    wait_in_ready();
                    d_in_valid = 1'b0;
                    if (abort) break;
                end
            end
            begin
                if (abort_at >= 0) begin
                    int t = 0;
                    while (n_en < abort_at && t < 2000) begin
                        @(negedge clk);
                        t++;
                    end
                    check_eq("abort_point", 64'(n_en), 64'(abort_at));
                    #2;
                    rst_n = 1'b0;
                    abort = 1'b1;
                    #1;
                    check_idle_outputs("async_rst");
                    repeat (2) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    exp_q.delete();
                    phase = 1'b0;
                    @(negedge clk);
                    check_eq("post_rst_cmd_ready", 64'(m_cmd_ready), 64'd1);
                    check_eq("post_rst_en", 64'(m_en), 64'd0);
                end
            end
        join
        if (!abort) begin
            int t = 0;
            while (done_cnt == d0 && t < 5000) begin
                @(negedge clk);
                t++;
            end
            check_eq("done_pulse", 64'(done_cnt - d0), 64'd1);
            check_eq("enabled_cycles", 64'(n_en), 64'(rows * ncol + ncol));
            check_eq("starve_cycles", 64'(n_stall), 64'(exp_stall));
            check_eq("exp_left", 64'(exp_q.size()), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Raises a second command during the flush and follows it to acceptance.
    task automatic intrude(input logic [3:0] op1, input logic [3:0] op2);
        int t = 0;
        while (!m_finish && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("flush_seen", 64'(m_finish), 64'd1);
        @(posedge clk);
        #1;
        d_cmd_op = op2;
        d_cmd_rows = 8'd0;
        d_cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            if (!m_cmd_ready) check_eq("op_hold_busy", 64'(m_op), 64'(op1));
        end while (!m_cmd_ready && t < 100);
        check_eq("op_kept_idle", 64'(m_op), 64'(op1));
        @(posedge clk);
        #1;
        d_cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("op_new", 64'(m_op), 64'(op2));
        check_eq("busy_new", 64'(m_busy), 64'd1);
        @(negedge clk);
        check_eq("done_new", 64'(m_done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int e0;
        sel = 1'b0;
        rst_n = 1'b0;
        d_cmd_valid = 1'b0;
        d_cmd_op = '0;
        d_cmd_rows = '0;
        d_in_valid = 1'b0;
        d_in_data = '0;
        for (int i = 0; i < 32; i++) begin
            words[i] = '0;
            gaps[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_a");
        sel = 1'b1;
        #1;
        check_idle_outputs("reset_b");
        sel = 1'b0;
        @(posedge clk);
        #1;

        // 32 columns: ascending then descending nibbles, no bubbles
        words[0] = 64'hFEDCBA9876543210;
        words[1] = 64'h0123456789ABCDEF;
        run_cmd(1, 4'h1, -1);

        // starvation of exactly three cycles between the two words
        gaps[1] = 3;
        run_cmd(1, 4'h1, -1);
        gaps[1] = 0;

        // zero-row command
        e0 = n_en;
        d_cmd_op = 4'h5;
        d_cmd_rows = 8'd0;
        d_cmd_valid = 1'b1;
        @(negedge clk);
        check_eq("zero_cmd_ready", 64'(m_cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        d_cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("zero_done_early", 64'(m_done), 64'd0);
        check_eq("zero_busy", 64'(m_busy), 64'd1);
        check_eq("zero_in_ready", 64'(m_in_ready), 64'd0);
        @(negedge clk);
        check_eq("zero_done", 64'(m_done), 64'd1);
        check_eq("zero_idle", 64'(m_busy), 64'd0);
        check_eq("zero_op", 64'(m_op), 64'h5);
        check_eq("zero_no_enable", 64'(n_en), 64'(e0));
        @(posedge clk);
        #1;

        // command offered during flush is held off until idle
        fork
            run_cmd(1, 4'h1, -1);
            intrude(4'h1, 4'h9);
        join

        // 20 columns, three rows: partial second word per row
        sel = 1'b1;
        fill_words(6, 1'b0);
        run_cmd(3, 4'h3, -1);

        for (int k = 0; k < 6; k++) begin
            int rows = int'($urandom_range(1, 4));
            fill_words(rows * 2, 1'b1);
            run_cmd(rows, 4'($urandom_range(0, 15)), -1);
        end

        // reset in the middle of the second row, then a clean command
        fill_words(6, 1'b0);
        run_cmd(3, 4'h7, 28);
        fill_words(2, 1'b0);
        run_cmd(1, 4'h2, -1);

        sel = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            int rows = int'($urandom_range(1, 3));
            fill_words(rows * 2, 1'b1);
            run_cmd(rows, 4'($urandom_range(0, 15)), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
